// File: rtl/decode_hazard_if.sv
// Fetch/execute-facing bundle of the decode stage: instruction in, fetch steering
// back out, and the ID pipeline register toward execute.
interface decode_hazard_if #(
  parameter int unsigned ADDRW = 8,
  parameter int unsigned REGW  = 5,
  parameter int unsigned CNTW  = 8
);
  logic [23:0]      ins;
  logic             zero_flag;
  logic             pc_mux_sel;
  logic [ADDRW-1:0] jmp_loc;
  logic             Stall;
  logic             Stall_pm;
  logic             id_valid;
  logic [4:0]       id_opcode;
  logic [REGW-1:0]  id_rd;
  logic [REGW-1:0]  id_rs1;
  logic [REGW-1:0]  id_rs2;
  logic [8:0]       id_imm;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_mem_write;
  logic             id_sets_flag;
  logic             halted;
  logic [CNTW-1:0]  stall_count;

  modport master (
    output ins, zero_flag,
    input  pc_mux_sel, jmp_loc, Stall, Stall_pm,
    input  id_valid, id_opcode, id_rd, id_rs1, id_rs2, id_imm,
    input  id_reg_write, id_mem_read, id_mem_write, id_sets_flag,
    input  halted, stall_count
  );

  modport slave (
    input  ins, zero_flag,
    output pc_mux_sel, jmp_loc, Stall, Stall_pm,
    output id_valid, id_opcode, id_rd, id_rs1, id_rs2, id_imm,
    output id_reg_write, id_mem_read, id_mem_write, id_sets_flag,
    output halted, stall_count
  );
endinterface

// File: rtl/decode_hazard_unit.sv
// Instruction decode stage: decodes ins into the ID register, resolves JMP/BZ,
// inserts one-cycle bubbles for load-use and flag-use hazards, and implements HALT.
module decode_hazard_unit #(
  parameter int unsigned ADDRW = 8,
  parameter int unsigned REGW  = 5,
  parameter int unsigned CNTW  = 8
) (
  input logic             clk,
  input logic             reset,
  decode_hazard_if.slave  bus
);

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_LOAD  = 5'b10000;
  localparam logic [4:0] OP_STORE = 5'b10001;
  localparam logic [4:0] OP_ADDI  = 5'b10010;
  localparam logic [4:0] OP_JMP   = 5'b11000;
  localparam logic [4:0] OP_BZ    = 5'b11001;
  localparam logic [4:0] OP_HLT   = 5'b11111;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic            valid;
    logic [4:0]      opcode;
    logic [REGW-1:0] rd;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [8:0]      imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            sets_flag;
  } id_reg_t;

  state_t          state_q, state_d;
  id_reg_t         id_q, id_d, dec;
  logic [CNTW-1:0] stall_cnt_q;
  logic            stall, pc_sel;
  logic [ADDRW-1:0] jmp_loc;

  logic [4:0]      opcode;
  logic [REGW-1:0] rd, rs1, rs2;
  logic is_alu, is_load, is_store, is_addi, is_jmp, is_bz, is_hlt;
  logic reads_rs1, reads_rs2, load_use, flag_use, hazard;

  // Field extraction and opcode classification of the incoming instruction
  always_comb begin
    opcode    = bus.ins[23:19];
    rd        = REGW'(bus.ins[18:14]);
    rs1       = REGW'(bus.ins[13:9]);
    rs2       = REGW'(bus.ins[8:4]);
    is_alu    = (opcode != OP_NOP) && (opcode[4] == 1'b0);
    is_load   = (opcode == OP_LOAD);
    is_store  = (opcode == OP_STORE);
    is_addi   = (opcode == OP_ADDI);
    is_jmp    = (opcode == OP_JMP);
    is_bz     = (opcode == OP_BZ);
    is_hlt    = (opcode == OP_HLT);
    reads_rs1 = is_alu | is_load | is_store | is_addi;
    reads_rs2 = is_alu | is_store;

    dec           = '0;
    dec.valid     = 1'b1;
    dec.opcode    = opcode;
    dec.rd        = rd;
    dec.rs1       = rs1;
    dec.rs2       = rs2;
    dec.imm       = bus.ins[8:0];
    dec.reg_write = (is_alu | is_load | is_addi) & (rd != '0);
    dec.mem_read  = is_load;
    dec.mem_write = is_store;
    dec.sets_flag = is_alu | is_addi;

    // r0 in ID never produces a hazard
    load_use = id_q.valid & id_q.mem_read & (id_q.rd != '0) &
               ((reads_rs1 & (rs1 == id_q.rd)) | (reads_rs2 & (rs2 == id_q.rd)));
    flag_use = is_bz & id_q.valid & id_q.sets_flag;
    hazard   = load_use | flag_use;
  end

  // Next state, fetch steering and ID register input; everything low in reset
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    pc_sel  = 1'b0;
    jmp_loc = '0;
    id_d    = '0;
    if (!reset) begin
      jmp_loc = ADDRW'(bus.ins[7:0]);
      case (state_q)
        HALT: stall = 1'b1;
        RUN: begin
          if (hazard) begin
            stall = 1'b1;
          end else if (is_jmp || (is_bz && bus.zero_flag)) begin
            pc_sel = 1'b1;
          end else if (is_hlt) begin
            state_d = HALT;
          end else if (!is_bz) begin
            id_d = dec;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      id_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      if (stall && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= CNTW'(stall_cnt_q + CNTW'(1));
      end
    end
  end

  assign bus.pc_mux_sel   = pc_sel;
  assign bus.jmp_loc      = jmp_loc;
  assign bus.Stall        = stall;
  assign bus.Stall_pm     = stall;
  assign bus.id_valid     = id_q.valid;
  assign bus.id_opcode    = id_q.opcode;
  assign bus.id_rd        = id_q.rd;
  assign bus.id_rs1       = id_q.rs1;
  assign bus.id_rs2       = id_q.rs2;
  assign bus.id_imm       = id_q.imm;
  assign bus.id_reg_write = id_q.reg_write;
  assign bus.id_mem_read  = id_q.mem_read;
  assign bus.id_mem_write = id_q.mem_write;
  assign bus.id_sets_flag = id_q.sets_flag;
  assign bus.halted       = (state_q == HALT);
  assign bus.stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_decode_hazard_unit.sv
// Directed-vector bench for decode_hazard_unit: the driver queues hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_decode_hazard_unit;

  logic clk;
  logic reset;

  decode_hazard_if bus ();

  decode_hazard_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected view of one cycle: combinational outputs for this cycle's ins,
  // registered outputs as left by the previous edge. idi is the instruction
  // expected in ID (fields sliced from it), ctl = {reg_write, mem_read, mem_write, sets_flag}.
  typedef struct {
    string       nm;
    logic        st;
    logic        pcs;
    logic [7:0]  jl;
    logic        hlt;
    logic [7:0]  cnt;
    logic        vld;
    logic [23:0] idi;
    logic [3:0]  ctl;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input string fld, input logic [23:0] act, input logic [23:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
    else n_pass++;
  endtask

  task automatic cyc(input string nm, input logic r, input logic [23:0] i, input logic zf,
                     input logic st, input logic pcs, input logic [7:0] jl,
                     input logic hlt, input logic [7:0] cnt,
                     input logic vld, input logic [23:0] idi, input logic [3:0] ctl);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = r;
    bus.ins       = i;
    bus.zero_flag = zf;
    e = '{nm: nm, st: st, pcs: pcs, jl: jl, hlt: hlt, cnt: cnt, vld: vld, idi: idi, ctl: ctl};
    q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "Stall",       24'(bus.Stall),       24'(e.st));
        chk(e.nm, "Stall_pm",    24'(bus.Stall_pm),    24'(e.st));
        chk(e.nm, "pc_mux_sel",  24'(bus.pc_mux_sel),  24'(e.pcs));
        chk(e.nm, "jmp_loc",     24'(bus.jmp_loc),     24'(e.jl));
        chk(e.nm, "halted",      24'(bus.halted),      24'(e.hlt));
        chk(e.nm, "stall_count", 24'(bus.stall_count), 24'(e.cnt));
        chk(e.nm, "id_valid",    24'(bus.id_valid),    24'(e.vld));
        if (e.vld) begin
          chk(e.nm, "id_opcode", 24'(bus.id_opcode), 24'(e.idi[23:19]));
          chk(e.nm, "id_rd",     24'(bus.id_rd),     24'(e.idi[18:14]));
          chk(e.nm, "id_rs1",    24'(bus.id_rs1),    24'(e.idi[13:9]));
          chk(e.nm, "id_rs2",    24'(bus.id_rs2),    24'(e.idi[8:4]));
          chk(e.nm, "id_imm",    24'(bus.id_imm),    24'(e.idi[8:0]));
          chk(e.nm, "id_ctl",
              24'({bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_sets_flag}),
              24'(e.ctl));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset         = 1'b1;
    bus.ins       = 24'h0;
    bus.zero_flag = 1'b0;

    //  name        rst ins         zf  st pcs jl     hlt cnt    vld idi         ctl
    cyc("reset",    1, 24'h090620, 0,  0, 0, 8'h00, 0, 8'd0,  0, 24'h0,      4'b0000);
    cyc("add_in",   0, 24'h090620, 0,  0, 0, 8'h20, 0, 8'd0,  0, 24'h0,      4'b0000);
    cyc("load_in",  0, 24'h80C200, 0,  0, 0, 8'h00, 0, 8'd0,  1, 24'h090620, 4'b1001);
    cyc("ld_use",   0, 24'h090620, 0,  1, 0, 8'h20, 0, 8'd0,  1, 24'h80C200, 4'b1100);
    cyc("ld_retry", 0, 24'h090620, 0,  0, 0, 8'h20, 0, 8'd1,  0, 24'h0,      4'b0000);
    cyc("ld_r0",    0, 24'h800200, 0,  0, 0, 8'h00, 0, 8'd1,  1, 24'h090620, 4'b1001);
    cyc("use_r0",   0, 24'h090000, 0,  0, 0, 8'h00, 0, 8'd1,  1, 24'h800200, 4'b0100);
    cyc("jmp",      0, 24'hC0002A, 0,  0, 1, 8'h2A, 0, 8'd1,  1, 24'h090000, 4'b1001);
    cyc("jmp_tgt",  0, 24'h090620, 0,  0, 0, 8'h20, 0, 8'd1,  0, 24'h0,      4'b0000);
    cyc("bz_fl1",   0, 24'hC80010, 1,  1, 0, 8'h10, 0, 8'd1,  1, 24'h090620, 4'b1001);
    cyc("bz_take",  0, 24'hC80010, 1,  0, 1, 8'h10, 0, 8'd2,  0, 24'h0,      4'b0000);
    cyc("bz_tgt",   0, 24'h090620, 0,  0, 0, 8'h20, 0, 8'd2,  0, 24'h0,      4'b0000);
    cyc("bz_fl0",   0, 24'hC80010, 0,  1, 0, 8'h10, 0, 8'd2,  1, 24'h090620, 4'b1001);
    cyc("bz_nt",    0, 24'hC80010, 0,  0, 0, 8'h10, 0, 8'd3,  0, 24'h0,      4'b0000);
    cyc("ld_r5",    0, 24'h814200, 0,  0, 0, 8'h00, 0, 8'd3,  0, 24'h0,      4'b0000);
    cyc("st_rs2",   0, 24'h880250, 0,  1, 0, 8'h50, 0, 8'd3,  1, 24'h814200, 4'b1100);
    cyc("st_retry", 0, 24'h880250, 0,  0, 0, 8'h50, 0, 8'd4,  0, 24'h0,      4'b0000);
    cyc("hlt",      0, 24'hF80000, 0,  0, 0, 8'h00, 0, 8'd4,  1, 24'h880250, 4'b0010);

    // HALT holds Stall and bubbles; the counter runs up to saturation
    for (int k = 1; k <= 300; k++) begin
      c = 3 + k;
      cyc("halt", 0, 24'h090620, 0, 1, 0, 8'h20, 1, (c > 255) ? 8'hFF : 8'(c), 0, 24'h0, 4'b0000);
    end

    cyc("rst_halt", 1, 24'h090620, 0, 0, 0, 8'h00, 1, 8'hFF, 0, 24'h0,      4'b0000);
    cyc("post_rst", 0, 24'h090620, 0, 0, 0, 8'h20, 0, 8'd0,  0, 24'h0,      4'b0000);
    cyc("add_agn",  0, 24'h000000, 0, 0, 0, 8'h00, 0, 8'd0,  1, 24'h090620, 4'b1001);

    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if (q.size() != 0) $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
